// File: rtl/ps2_pkg.sv
// Shared scan codes, heading encodings and frame-receiver states for the PS/2 key controller.
// Also holds the key-to-heading map and the turn legality rule.
package ps2_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_UP_ARW  = 8'h75;
    localparam logic [7:0] SC_DN_ARW  = 8'h72;
    localparam logic [7:0] SC_LT_ARW  = 8'h6B;
    localparam logic [7:0] SC_RT_ARW  = 8'h74;
    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_D       = 8'h23;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_dir_t;

    // Arrow keys only count with the E0 prefix; WASD only without it.
    function automatic key_dir_t key_to_dir(input logic ext, input logic [7:0] sc);
        key_dir_t r;
        r = '{hit: 1'b0, dir: DIR_UP};
        if (ext) begin
            case (sc)
                SC_UP_ARW: r = '{hit: 1'b1, dir: DIR_UP};
                SC_DN_ARW: r = '{hit: 1'b1, dir: DIR_DOWN};
                SC_LT_ARW: r = '{hit: 1'b1, dir: DIR_LEFT};
                SC_RT_ARW: r = '{hit: 1'b1, dir: DIR_RIGHT};
                default:   r = '{hit: 1'b0, dir: DIR_UP};
            endcase
        end else begin
            case (sc)
                SC_W:    r = '{hit: 1'b1, dir: DIR_UP};
                SC_S:    r = '{hit: 1'b1, dir: DIR_DOWN};
                SC_A:    r = '{hit: 1'b1, dir: DIR_LEFT};
                SC_D:    r = '{hit: 1'b1, dir: DIR_RIGHT};
                default: r = '{hit: 1'b0, dir: DIR_UP};
            endcase
        end
        return r;
    endfunction

    // Opposite headings differ only in bit 1, so that xor pattern is a reversal.
    function automatic logic turn_ok(input logic [1:0] cur, input logic [1:0] nxt);
        return (nxt != cur) && ((nxt ^ cur) != 2'b10);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Event bundle from the key controller to the game FSM and the display driver.
// All fields are registered by the controller; pulses last exactly one clk cycle.
interface ps2_key_ctrl_if;
    logic       code_valid;
    logic [7:0] code;
    logic       code_ext;
    logic       code_break;
    logic       frame_err;
    logic [1:0] dir;
    logic       dir_changed;
    logic [7:0] last_pressed;

    modport master (
        output code_valid, code, code_ext, code_break, frame_err, dir, dir_changed, last_pressed
    );
    modport slave (
        input  code_valid, code, code_ext, code_break, frame_err, dir, dir_changed, last_pressed
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// Synchronises PS2Clk/PS2Data, frames 11-bit words and checks parity, stop bit and inter-edge timeout.
// Strobes are combinational in the cycle the stop edge is detected; no back-pressure.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_stb_o,
    output logic [7:0] byte_o,
    output logic       err_stb_o
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall, dat, timeout, frame_done, frame_good;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign dat     = dat_sync_q[1];
    assign timeout = (state_q != ST_IDLE) && !fall && (tmo_q == TMO_LAST);

    // Sync flops reset high so a released reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = (fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (fall && !dat) state_d = ST_DATA;
            end
            ST_DATA: if (fall) begin
                shift_d   = {dat, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: if (fall) begin
                par_d   = dat;
                state_d = ST_STOP;
            end
            ST_STOP: if (fall) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_IDLE;
    end

    always_comb begin
        frame_done = (state_q == ST_STOP) && fall;
        frame_good = (^shift_q ^ par_q) && dat;
        byte_stb_o = frame_done && frame_good;
        err_stb_o  = (frame_done && !frame_good) || timeout;
        byte_o     = shift_q;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into make/break events and steers the snake heading.
// Events appear one cycle after the stop-bit edge is detected; no back-pressure, consumers must sample.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 100_000,
    parameter logic [1:0] DIR_INIT    = 2'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PS2Clk,
    input  logic              PS2Data,
    ps2_key_ctrl_if.master    evt
);
    logic       rx_stb, rx_err;
    logic [7:0] rx_byte;
    key_dir_t   kd;

    logic       ext_q, ext_d, brk_q, brk_d;
    logic       code_valid_q, code_valid_d;
    logic [7:0] code_q, code_d;
    logic       code_ext_q, code_ext_d, code_break_q, code_break_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_changed_q, dir_changed_d;
    logic [7:0] last_q, last_d;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (PS2Clk),
        .ps2_dat_i  (PS2Data),
        .byte_stb_o (rx_stb),
        .byte_o     (rx_byte),
        .err_stb_o  (rx_err)
    );

    assign kd = key_to_dir(ext_q, rx_byte);

    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        code_valid_d  = 1'b0;
        code_d        = code_q;
        code_ext_d    = code_ext_q;
        code_break_d  = code_break_q;
        frame_err_d   = rx_err;
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        last_d        = last_q;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_stb) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_d       = rx_byte;
                code_ext_d   = ext_q;
                code_break_d = brk_q;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                // Releases never steer or update the display value.
                if (!brk_q) begin
                    last_d = rx_byte;
                    if (kd.hit && turn_ok(dir_q, kd.dir)) begin
                        dir_d         = kd.dir;
                        dir_changed_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            code_valid_q  <= 1'b0;
            code_q        <= '0;
            code_ext_q    <= 1'b0;
            code_break_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            dir_q         <= DIR_INIT;
            dir_changed_q <= 1'b0;
            last_q        <= '0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            code_valid_q  <= code_valid_d;
            code_q        <= code_d;
            code_ext_q    <= code_ext_d;
            code_break_q  <= code_break_d;
            frame_err_q   <= frame_err_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            last_q        <= last_d;
        end
    end

    assign evt.code_valid   = code_valid_q;
    assign evt.code         = code_q;
    assign evt.code_ext     = code_ext_q;
    assign evt.code_break   = code_break_q;
    assign evt.frame_err    = frame_err_q;
    assign evt.dir          = dir_q;
    assign evt.dir_changed  = dir_changed_q;
    assign evt.last_pressed = last_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: table of key sequences plus error, timeout and mid-frame reset cases.
module tb_ps2_key_ctrl;
    localparam int TMO = 400;

    logic clk = 1'b0;
    logic rst_n;
    logic ps2_clk;
    logic ps2_dat;

    always #5 clk = ~clk;

    ps2_key_ctrl_if evt ();

    ps2_key_ctrl #(.TIMEOUT_CYC(TMO), .DIR_INIT(2'd1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PS2Clk  (ps2_clk),
        .PS2Data (ps2_dat),
        .evt     (evt)
    );

    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_dch = 0;
    int last_err_cyc = 0;
    int last_fall_cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (evt.code_valid)  n_valid <= n_valid + 1;
        if (evt.dir_changed) n_dch <= n_dch + 1;
        if (evt.frame_err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_dat = w[i];
            #60;
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            #60;
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mkframe(b, 1'b0), 0, 10);
        #200;
    endtask

    typedef struct {
        int         npre;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] key;
        logic       ext;
        logic       brk;
        logic [1:0] dir;
        logic       dch;
        logic [7:0] lp;
    } vec_t;

    vec_t vecs[11];

    int b_valid, b_err, b_dch;

    task automatic snap();
        b_valid = n_valid;
        b_err   = n_err;
        b_dch   = n_dch;
    endtask

    initial begin
        vecs[0]  = '{0, 8'h00, 8'h00, 8'h1D, 1'b0, 1'b0, 2'd0, 1'b1, 8'h1D};
        vecs[1]  = '{1, 8'hE0, 8'h00, 8'h6B, 1'b1, 1'b0, 2'd3, 1'b1, 8'h6B};
        vecs[2]  = '{2, 8'hE0, 8'hF0, 8'h6B, 1'b1, 1'b1, 2'd3, 1'b0, 8'h6B};
        vecs[3]  = '{0, 8'h00, 8'h00, 8'h1C, 1'b0, 1'b0, 2'd3, 1'b0, 8'h1C};
        vecs[4]  = '{0, 8'h00, 8'h00, 8'h1B, 1'b0, 1'b0, 2'd2, 1'b1, 8'h1B};
        vecs[5]  = '{0, 8'h00, 8'h00, 8'h1D, 1'b0, 1'b0, 2'd2, 1'b0, 8'h1D};
        vecs[6]  = '{2, 8'hF0, 8'hE0, 8'h72, 1'b1, 1'b1, 2'd2, 1'b0, 8'h1D};
        vecs[7]  = '{2, 8'hE0, 8'hE0, 8'h74, 1'b1, 1'b0, 2'd1, 1'b1, 8'h74};
        vecs[8]  = '{1, 8'hE0, 8'h00, 8'h6B, 1'b1, 1'b0, 2'd1, 1'b0, 8'h6B};
        vecs[9]  = '{0, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 2'd1, 1'b0, 8'h5A};
        vecs[10] = '{0, 8'h00, 8'h00, 8'h23, 1'b0, 1'b0, 2'd1, 1'b0, 8'h23};

        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        #42;
        check("rst code_valid", 32'(evt.code_valid), 32'h0);
        check("rst code", 32'(evt.code), 32'h0);
        check("rst dir", 32'(evt.dir), 32'h1);
        check("rst last_pressed", 32'(evt.last_pressed), 32'h0);
        check("rst frame_err", 32'(evt.frame_err), 32'h0);
        rst_n = 1'b1;
        #40;

        for (int v = 0; v < 11; v++) begin
            snap();
            if (vecs[v].npre >= 1) send_byte(vecs[v].p0);
            if (vecs[v].npre >= 2) send_byte(vecs[v].p1);
            send_byte(vecs[v].key);
            check($sformatf("v%0d valid_cnt", v), 32'(n_valid - b_valid), 32'd1);
            check($sformatf("v%0d code", v), 32'(evt.code), 32'(vecs[v].key));
            check($sformatf("v%0d ext", v), 32'(evt.code_ext), 32'(vecs[v].ext));
            check($sformatf("v%0d brk", v), 32'(evt.code_break), 32'(vecs[v].brk));
            check($sformatf("v%0d dir", v), 32'(evt.dir), 32'(vecs[v].dir));
            check($sformatf("v%0d dch_cnt", v), 32'(n_dch - b_dch), 32'(vecs[v].dch));
            check($sformatf("v%0d last_pressed", v), 32'(evt.last_pressed), 32'(vecs[v].lp));
            check($sformatf("v%0d err_cnt", v), 32'(n_err - b_err), 32'd0);
        end

        // Bad parity after E0: error pulse, prefix dropped for the next byte.
        snap();
        send_byte(8'hE0);
        send_bits(mkframe(8'h23, 1'b1), 0, 10);
        #200;
        check("par err_cnt", 32'(n_err - b_err), 32'd1);
        check("par valid_cnt", 32'(n_valid - b_valid), 32'd0);
        snap();
        send_byte(8'h1B);
        check("par next valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("par next code", 32'(evt.code), 32'h1B);
        check("par next ext", 32'(evt.code_ext), 32'h0);
        check("par next dir", 32'(evt.dir), 32'h2);

        // Abandoned frame after start + 5 data bits.
        snap();
        send_bits(mkframe(8'h1C, 1'b0), 0, 5);
        #((TMO + 30) * 10);
        check("tmo err_cnt", 32'(n_err - b_err), 32'd1);
        check("tmo valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("tmo err_late", 32'(last_err_cyc - last_fall_cyc >= TMO), 32'd1);
        check("tmo err_early", 32'(last_err_cyc - last_fall_cyc <= TMO + 5), 32'd1);
        snap();
        send_byte(8'h1C);
        check("tmo next valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("tmo next code", 32'(evt.code), 32'h1C);
        check("tmo next dir", 32'(evt.dir), 32'h3);
        check("tmo next dch_cnt", 32'(n_dch - b_dch), 32'd1);

        // Reset in the middle of a frame.
        send_bits(mkframe(8'h1D, 1'b0), 0, 3);
        rst_n = 1'b0;
        #30;
        check("mrst code", 32'(evt.code), 32'h0);
        check("mrst dir", 32'(evt.dir), 32'h1);
        check("mrst last_pressed", 32'(evt.last_pressed), 32'h0);
        check("mrst code_valid", 32'(evt.code_valid), 32'h0);
        rst_n = 1'b1;
        #20;
        snap();
        send_bits(mkframe(8'h1D, 1'b0), 4, 10);
        #((TMO + 30) * 10);
        check("mrst tail valid_cnt", 32'(n_valid - b_valid), 32'd0);
        snap();
        send_byte(8'h1D);
        check("mrst new valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("mrst new code", 32'(evt.code), 32'h1D);
        check("mrst new dir", 32'(evt.dir), 32'h0);
        check("mrst new dch_cnt", 32'(n_dch - b_dch), 32'd1);
        check("mrst new last_pressed", 32'(evt.last_pressed), 32'h1D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
